// File: rtl/bus_protocol_checker.sv
// Passive monitor for one master/slave pair on the OCP-style Bus link.
// It raises sticky violation flags and a one-cycle error pulse, and counts the responses still outstanding.
module bus_protocol_checker #(
    parameter int   addr_width       = 32,
    parameter int   data_width       = 32,
    parameter logic byteen           = 1'b0,
    parameter logic writeresp_enable = 1'b1,
    parameter int   cnt_width        = 4
) (
    input  logic                    Clk,
    input  logic                    MReset_n,
    input  logic [addr_width-1:0]   MAddr,
    input  logic [2:0]              MCmd,
    input  logic [data_width-1:0]   MData,
    input  logic [data_width/8-1:0] MByteEn,
    input  logic                    MRespAccept,
    input  logic                    SCmdAccept,
    input  logic [data_width-1:0]   SData,
    input  logic [1:0]              SResp,
    input  logic                    clear,
    output logic                    err_req_unstable,
    output logic                    err_resp_unstable,
    output logic                    err_bad_resp,
    output logic                    err_byteen,
    output logic                    err_orphan_resp,
    output logic                    err_overflow,
    output logic                    error,
    output logic [cnt_width-1:0]    num_in_flight
);

    localparam int BE_W = data_width / 8;
    localparam logic [cnt_width-1:0] CNT_MAX = '1;
    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        CMD_IDLE = 3'b000,
        CMD_WR   = 3'b001,
        CMD_RD   = 3'b010
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        RESP_NULL = 2'b00,
        RESP_DVA  = 2'b01,
        RESP_FAIL = 2'b10,
        RESP_ERR  = 2'b11
    } ocp_resp_e;

    logic                  r_req_pend;
    logic [2:0]            r_cmd;
    logic [addr_width-1:0] r_addr;
    logic [data_width-1:0] r_data;
    logic [BE_W-1:0]       r_be;
    logic                  r_rsp_pend;
    logic [1:0]            r_resp;
    logic [data_width-1:0] r_sdata;
    logic                  r_be_valid;
    logic [BE_W-1:0]       r_be_ref;
    logic [cnt_width-1:0]  r_count;
    logic                  r_err_req;
    logic                  r_err_rsp;
    logic                  r_err_bad;
    logic                  r_err_be;
    logic                  r_err_orphan;
    logic                  r_err_ovf;
    logic                  r_error;

    logic                  w_req_valid;
    logic                  w_be_differs;
    logic                  w_det_req;
    logic                  w_det_rsp;
    logic                  w_det_bad;
    logic                  w_det_be;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_det_orphan;
    logic                  w_det_ovf;
    logic [cnt_width-1:0]  w_count_next;

    assign w_req_valid  = (MCmd != CMD_IDLE);
    assign w_be_differs = byteen ? (MByteEn != r_be) : 1'b0;
    assign w_det_req    = r_req_pend && ((MCmd != r_cmd) || (MAddr != r_addr) ||
                                         (MData != r_data) || w_be_differs);
    assign w_det_rsp    = r_rsp_pend && ((SResp != r_resp) || (SData != r_sdata));
    assign w_det_bad    = (SResp == RESP_FAIL) || (SResp == RESP_ERR);
    assign w_det_be     = !byteen && r_be_valid && (MByteEn != r_be_ref);

    // Writes only occupy a slot when the slave is expected to answer them.
    assign w_inc        = w_req_valid && SCmdAccept && (writeresp_enable || (MCmd != CMD_WR));
    assign w_dec        = (SResp != RESP_NULL) && MRespAccept;
    assign w_det_orphan = w_dec && !w_inc && (r_count == '0);
    assign w_det_ovf    = w_inc && !w_dec && (r_count == CNT_MAX);

    always_comb begin
        w_count_next = r_count;
        if (w_inc && !w_dec && !w_det_ovf) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_dec && !w_inc && !w_det_orphan) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // Capture continues on every unaccepted edge, so after a mismatch the new values become the reference.
    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            r_req_pend <= 1'b0;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_be       <= '0;
            r_rsp_pend <= 1'b0;
            r_resp     <= '0;
            r_sdata    <= '0;
            r_be_valid <= 1'b0;
            r_be_ref   <= '0;
        end else begin
            r_req_pend <= w_req_valid && !SCmdAccept;
            if (w_req_valid && !SCmdAccept) begin
                r_cmd  <= MCmd;
                r_addr <= MAddr;
                r_data <= MData;
                r_be   <= byteen ? MByteEn : '0;
            end
            r_rsp_pend <= (SResp == RESP_DVA) && !MRespAccept;
            if ((SResp == RESP_DVA) && !MRespAccept) begin
                r_resp  <= SResp;
                r_sdata <= SData;
            end
            r_be_valid <= 1'b1;
            r_be_ref   <= MByteEn;
        end
    end

    // A detection in the same cycle as clear keeps the sticky bit set.
    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            r_err_req    <= 1'b0;
            r_err_rsp    <= 1'b0;
            r_err_bad    <= 1'b0;
            r_err_be     <= 1'b0;
            r_err_orphan <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_error      <= 1'b0;
            r_count      <= '0;
        end else begin
            r_err_req    <= (r_err_req    && !clear) || w_det_req;
            r_err_rsp    <= (r_err_rsp    && !clear) || w_det_rsp;
            r_err_bad    <= (r_err_bad    && !clear) || w_det_bad;
            r_err_be     <= (r_err_be     && !clear) || w_det_be;
            r_err_orphan <= (r_err_orphan && !clear) || w_det_orphan;
            r_err_ovf    <= (r_err_ovf    && !clear) || w_det_ovf;
            r_error      <= w_det_req || w_det_rsp || w_det_bad || w_det_be ||
                            w_det_orphan || w_det_ovf;
            r_count      <= w_count_next;
        end
    end

    assign err_req_unstable  = r_err_req;
    assign err_resp_unstable = r_err_rsp;
    assign err_bad_resp      = r_err_bad;
    assign err_byteen        = r_err_be;
    assign err_orphan_resp   = r_err_orphan;
    assign err_overflow      = r_err_ovf;
    assign error             = r_error;
    assign num_in_flight     = r_count;

endmodule

// File: tb/tb_bus_protocol_checker.sv
// Directed bench for bus_protocol_checker: four parameter variants share one stimulus stream
// and are compared against hand-computed flags and counts.
module tb_bus_protocol_checker;

    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] WR   = 3'b001;
    localparam logic [2:0] RD   = 3'b010;
    localparam logic [1:0] RNUL = 2'b00;
    localparam logic [1:0] DVA  = 2'b01;
    localparam logic [1:0] FAIL = 2'b10;
    localparam logic [1:0] ERR  = 2'b11;

    logic        Clk = 1'b0;
    logic        MReset_n;
    logic [31:0] MAddr;
    logic [2:0]  MCmd;
    logic [31:0] MData;
    logic [3:0]  MByteEn;
    logic        MRespAccept;
    logic        SCmdAccept;
    logic [31:0] SData;
    logic [1:0]  SResp;
    logic        clear;

    // Error vectors are {overflow, orphan, byteen, bad_resp, resp_unstable, req_unstable}
    logic [5:0] errA, errBe, errSmall, errNoWr;
    logic       errorA, errorBe, errorSmall, errorNoWr;
    logic [3:0] cntA, cntBe, cntNoWr;
    logic [1:0] cntSmall;

    int assertCount = 0;
    int failCount   = 0;

    always #5 Clk = ~Clk;

    bus_protocol_checker dut (
        .Clk(Clk), .MReset_n(MReset_n), .MAddr(MAddr), .MCmd(MCmd), .MData(MData),
        .MByteEn(MByteEn), .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept),
        .SData(SData), .SResp(SResp), .clear(clear),
        .err_req_unstable(errA[0]), .err_resp_unstable(errA[1]), .err_bad_resp(errA[2]),
        .err_byteen(errA[3]), .err_orphan_resp(errA[4]), .err_overflow(errA[5]),
        .error(errorA), .num_in_flight(cntA)
    );

    bus_protocol_checker #(.byteen(1'b1)) dutBe (
        .Clk(Clk), .MReset_n(MReset_n), .MAddr(MAddr), .MCmd(MCmd), .MData(MData),
        .MByteEn(MByteEn), .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept),
        .SData(SData), .SResp(SResp), .clear(clear),
        .err_req_unstable(errBe[0]), .err_resp_unstable(errBe[1]), .err_bad_resp(errBe[2]),
        .err_byteen(errBe[3]), .err_orphan_resp(errBe[4]), .err_overflow(errBe[5]),
        .error(errorBe), .num_in_flight(cntBe)
    );

    bus_protocol_checker #(.cnt_width(2)) dutSmall (
        .Clk(Clk), .MReset_n(MReset_n), .MAddr(MAddr), .MCmd(MCmd), .MData(MData),
        .MByteEn(MByteEn), .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept),
        .SData(SData), .SResp(SResp), .clear(clear),
        .err_req_unstable(errSmall[0]), .err_resp_unstable(errSmall[1]), .err_bad_resp(errSmall[2]),
        .err_byteen(errSmall[3]), .err_orphan_resp(errSmall[4]), .err_overflow(errSmall[5]),
        .error(errorSmall), .num_in_flight(cntSmall)
    );

    bus_protocol_checker #(.writeresp_enable(1'b0)) dutNoWr (
        .Clk(Clk), .MReset_n(MReset_n), .MAddr(MAddr), .MCmd(MCmd), .MData(MData),
        .MByteEn(MByteEn), .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept),
        .SData(SData), .SResp(SResp), .clear(clear),
        .err_req_unstable(errNoWr[0]), .err_resp_unstable(errNoWr[1]), .err_bad_resp(errNoWr[2]),
        .err_byteen(errNoWr[3]), .err_orphan_resp(errNoWr[4]), .err_overflow(errNoWr[5]),
        .error(errorNoWr), .num_in_flight(cntNoWr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] cmd, input logic [31:0] addr, input logic sAcc,
                                 input logic [1:0] resp, input logic [31:0] sdata, input logic mAcc);
        MCmd        = cmd;
        MAddr       = addr;
        SCmdAccept  = sAcc;
        SResp       = resp;
        SData       = sdata;
        MRespAccept = mAcc;
        tick();
    endtask

    initial begin
        MReset_n = 1'b0;
        MData    = '0;
        MByteEn  = 4'hF;
        clear    = 1'b0;
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);
        checkOutput("reset_errs", {26'd0, errA}, 32'd0);
        checkOutput("reset_error", {31'd0, errorA}, 32'd0);
        checkOutput("reset_count", {28'd0, cntA}, 32'd0);
        MReset_n = 1'b1;
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);

        // Write held three cycles, accepted on the fourth
        MData = 32'hA5;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(WR, 32'h10, 0, RNUL, 0, 0);
            checkOutput("wr_hold_errs", {26'd0, errA}, 32'd0);
        end
        applyStimulus(WR, 32'h10, 1, RNUL, 0, 0);
        checkOutput("wr_acc_errs", {26'd0, errA}, 32'd0);
        checkOutput("wr_acc_count", {28'd0, cntA}, 32'd1);
        checkOutput("nowr_count", {28'd0, cntNoWr}, 32'd0);
        MData = '0;
        applyStimulus(IDLE, 0, 0, DVA, 0, 1);
        checkOutput("wr_resp_count", {28'd0, cntA}, 32'd0);
        checkOutput("wr_resp_orphan", {31'd0, errA[4]}, 32'd0);
        checkOutput("nowr_orphan", {31'd0, errNoWr[4]}, 32'd1);

        // Address changes while a read waits for acceptance
        applyStimulus(RD, 32'h10, 0, RNUL, 0, 0);
        checkOutput("rd_hold_err", {31'd0, errA[0]}, 32'd0);
        applyStimulus(RD, 32'h14, 0, RNUL, 0, 0);
        checkOutput("req_unstable", {31'd0, errA[0]}, 32'd1);
        checkOutput("req_error_pulse", {31'd0, errorA}, 32'd1);
        applyStimulus(RD, 32'h14, 1, RNUL, 0, 0);
        checkOutput("req_error_drop", {31'd0, errorA}, 32'd0);
        checkOutput("req_sticky", {31'd0, errA[0]}, 32'd1);
        checkOutput("rd_count", {28'd0, cntA}, 32'd1);
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);

        // Response data changes before acceptance, then an ERR code
        applyStimulus(IDLE, 0, 0, DVA, 32'h1234, 0);
        checkOutput("rsp_hold_err", {31'd0, errA[1]}, 32'd0);
        applyStimulus(IDLE, 0, 0, DVA, 32'h1235, 0);
        checkOutput("resp_unstable", {31'd0, errA[1]}, 32'd1);
        applyStimulus(IDLE, 0, 0, ERR, 0, 0);
        checkOutput("bad_resp", {31'd0, errA[2]}, 32'd1);
        clear = 1'b1;
        applyStimulus(IDLE, 0, 0, FAIL, 0, 0);
        checkOutput("clear_rsp", {31'd0, errA[1]}, 32'd0);
        checkOutput("clear_vs_detect", {31'd0, errA[2]}, 32'd1);
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);
        checkOutput("clear_all", {26'd0, errA}, 32'd0);
        clear = 1'b0;
        checkOutput("count_after_clear", {28'd0, cntA}, 32'd1);
        applyStimulus(IDLE, 0, 0, DVA, 32'h1235, 1);
        checkOutput("rd_resp_count", {28'd0, cntA}, 32'd0);
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);

        // Byte-enable change: flagged only without byte enables
        MByteEn = 4'h3;
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);
        checkOutput("byteen_err", {31'd0, errA[3]}, 32'd1);
        checkOutput("byteen_pulse", {31'd0, errorA}, 32'd1);
        checkOutput("byteen_on_err", {31'd0, errBe[3]}, 32'd0);
        checkOutput("byteen_on_pulse", {31'd0, errorBe}, 32'd0);
        MByteEn = 4'hF;
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);
        clear = 1'b1;
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);
        clear = 1'b0;
        checkOutput("byteen_cleared", {26'd0, errA}, 32'd0);

        // Orphan response with nothing in flight
        applyStimulus(IDLE, 0, 0, DVA, 0, 1);
        checkOutput("orphan", {31'd0, errA[4]}, 32'd1);
        checkOutput("orphan_count", {28'd0, cntA}, 32'd0);
        clear = 1'b1;
        applyStimulus(IDLE, 0, 0, RNUL, 0, 0);
        clear = 1'b0;

        // Four accepted reads overflow the 2-bit counter
        for (int i = 0; i < 3; i++) applyStimulus(RD, 32'h40, 1, RNUL, 0, 0);
        checkOutput("small_count3", {30'd0, cntSmall}, 32'd3);
        checkOutput("small_no_ovf", {31'd0, errSmall[5]}, 32'd0);
        applyStimulus(RD, 32'h40, 1, RNUL, 0, 0);
        checkOutput("small_sat", {30'd0, cntSmall}, 32'd3);
        checkOutput("small_ovf", {31'd0, errSmall[5]}, 32'd1);
        checkOutput("wide_count4", {28'd0, cntA}, 32'd4);
        checkOutput("wide_no_ovf", {31'd0, errA[5]}, 32'd0);
        applyStimulus(RD, 32'h40, 1, DVA, 0, 1);
        checkOutput("small_incdec", {30'd0, cntSmall}, 32'd3);
        checkOutput("small_incdec_err", {31'd0, errorSmall}, 32'd0);
        checkOutput("wide_incdec", {28'd0, cntA}, 32'd4);

        // Reset in the middle of a pending request
        applyStimulus(RD, 32'h20, 0, RNUL, 0, 0);
        MReset_n = 1'b0;
        #1;
        checkOutput("rst_count", {28'd0, cntA}, 32'd0);
        checkOutput("rst_small_errs", {26'd0, errSmall}, 32'd0);
        checkOutput("rst_small_count", {30'd0, cntSmall}, 32'd0);
        tick();
        MReset_n = 1'b1;
        applyStimulus(RD, 32'h30, 0, RNUL, 0, 0);
        checkOutput("post_rst_errs", {26'd0, errA}, 32'd0);
        checkOutput("post_rst_error", {31'd0, errorA}, 32'd0);
        applyStimulus(RD, 32'h30, 1, RNUL, 0, 0);
        checkOutput("post_rst_count", {28'd0, cntA}, 32'd1);
        checkOutput("post_rst_errs2", {26'd0, errA}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bus_protocol_checker.md
# bus_protocol_checker

Passive, synthesizable protocol monitor for the team's OCP-style `Bus` point-to-point link, attached in parallel to one master/slave pair.
- Observes every request and response signal and never drives the bus.
- Flags protocol violations through sticky error bits and a one-cycle error pulse.
- Tracks the number of accepted requests still awaiting a response.

It is used in hardware builds and on FPGA, where simulation-only assertions are unavailable.

## Interface
Parameters:
- `addr_width`, 32, width of `MAddr`
- `data_width`, 32, width of `MData`/`SData`; must be a multiple of 8
- `byteen`, 1'b0, 1 = byte enables in use; 0 = `MByteEn` must never change
- `writeresp_enable`, 1'b1, 1 = writes expect a response; 0 = accepted writes are not counted in flight
- `cnt_width`, 4, width of the outstanding-transaction counter

Ports:
- `Clk` input 1: sole clock, rising edge
- `MReset_n` input 1: asynchronous, active-low reset
- `MAddr` input addr_width: request address
- `MCmd` input 3: `Ocp_cmd` (IDLE=3'b000, WR=3'b001, RD=3'b010)
- `MData` input data_width: write data
- `MByteEn` input data_width/8: byte enables
- `MRespAccept` input 1: master accepts the response
- `SCmdAccept` input 1: slave accepts the request
- `SData` input data_width: read data
- `SResp` input 2: `Ocp_resp` (NULL=2'b00, DVA=2'b01, FAIL=2'b10, ERR=2'b11)
- `clear` input 1: synchronous clear of all sticky error bits
- `err_req_unstable` output 1: sticky, request changed before acceptance
- `err_resp_unstable` output 1: sticky, response changed before acceptance
- `err_bad_resp` output 1: sticky, `SResp` was FAIL or ERR
- `err_byteen` output 1: sticky, `MByteEn` changed while `byteen`=0
- `err_orphan_resp` output 1: sticky, response accepted with nothing in flight
- `err_overflow` output 1: sticky, in-flight counter would exceed its maximum
- `error` output 1: pulses for one cycle whenever any violation is detected
- `num_in_flight` output cnt_width: current outstanding count

## Operation
- **Request hold:**
  - When `MCmd`≠IDLE and `SCmdAccept`=0 at an edge, capture `MCmd`, `MAddr` and `MData`; also capture `MByteEn` if `byteen`=1. Set `req_pend`.
  - While `req_pend`=1, every subsequent edge compares the live signals with the captured copy. Any difference sets `err_req_unstable`; a command dropping to IDLE counts as a difference.
  - `req_pend` clears at the edge where `SCmdAccept`=1.
  - If the request is still unaccepted at that edge (after a mismatch), re-capture the new values.
- **Response hold:**
  - When `SResp`=DVA and `MRespAccept`=0, capture `SResp` and `SData` and set `rsp_pend`.
  - While `rsp_pend`=1, any difference sets `err_resp_unstable`.
  - `rsp_pend` clears when `MRespAccept`=1.
- **Response codes:** `SResp` of FAIL or ERR at any edge sets `err_bad_resp`.
- **Byte-enable option:** when `byteen`=0, `MByteEn` differing from its value at the previous edge sets `err_byteen`. The first edge after reset only loads the reference value. When `byteen`=1 this check is disabled.
- **In-flight counter:**
  - `inc` = `MCmd`≠IDLE and `SCmdAccept`=1, excluding WR when `writeresp_enable`=0.
  - `dec` = `SResp`≠NULL and `MRespAccept`=1.
  - Next count = count + `inc` − `dec`.
  - `dec` with count=0 and no simultaneous `inc`: set `err_orphan_resp` and hold the count at 0.
  - `inc` with count at all-ones and no `dec`: set `err_overflow` and hold the count (saturate).
- `error` = OR of the per-cycle detect terms, registered.
- `clear`=1 zeroes the sticky bits. A detection in the same cycle wins, so the bit stays set.

## Timing
- All checks sample on the rising edge of `Clk`. Sticky bits, `error` and `num_in_flight` update at that same edge and are visible right after it. Detection latency is 0 cycles past the sampling edge.
- Reset (`MReset_n`=0, asynchronous) forces to 0: all error outputs, `error`, `num_in_flight`, `req_pend`, `rsp_pend`, and the byteen reference-valid flag.
- While in reset no check fires. Reset in mid-transaction discards all pending state.
- Simultaneous `inc` and `dec` leave the count unchanged, including at 0 and at the maximum.

## Test plan
- WR at addr 0x10, data 0xA5, held 3 cycles with `SCmdAccept`=0, accepted on the 4th → no errors, `num_in_flight`=1. Then a DVA response accepted → `num_in_flight`=0.
- RD pending with `SCmdAccept`=0, `MAddr` changes 0x10→0x14 on the next cycle → `err_req_unstable`=1 and `error` high for exactly one cycle.
- DVA response with `SData`=0x1234 held while `MRespAccept`=0, `SData` changes to 0x1235 → `err_resp_unstable`=1. Then `SResp`=ERR → `err_bad_resp`=1. Then `clear`=1 → both bits return to 0.
- `byteen`=0 and `MByteEn` toggles 0xF→0x3 → `err_byteen`=1. The same stimulus with `byteen`=1 → no error.
- DVA accepted with `num_in_flight`=0 → `err_orphan_resp`=1, count stays 0. With `cnt_width`=2, issue four accepted RDs with no responses → count 3, `err_overflow`=1.
- Deassert `MReset_n` mid-pending request → all outputs are 0 immediately. After release, a fresh request produces no spurious error.
